// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD,
    S_ERR
  } fetch_state_e;

  localparam logic [1:0] ERR_NONE     = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT  = 2'b01;
  localparam logic [1:0] ERR_MISALIGN = 2'b10;

  localparam int unsigned TIMEOUT_DEF = 255;

endpackage

// File: rtl/fetch_wdog.sv
// Wait-cycle watchdog for the fetch stage memory handshake.
module fetch_wdog
  import fetch_pkg::*;
#(
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic clk,
  input  logic areset,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Fires in the TIMEOUT-th enabled cycle
  assign expired = en & (cnt_q == LAST);

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC -> imem req/ack -> decode valid/ready.
// Optional alignment check enabled by FETCH_ALIGN_CHECK_EN.
module instr_fetch
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              areset,
  input  logic [ADDR_W-1:0] pc,
  output logic              pc_load,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              fetch_err,
  output logic [1:0]        err_code
);

  fetch_state_e      state_q, state_d;
  logic [1:0]        err_q, err_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] ipc_q, ipc_d;

  logic wd_clr;
  logic wd_en;
  logic wd_exp;
  logic misalign;

`ifdef FETCH_ALIGN_CHECK_EN
  assign misalign = |pc[1:0];
`else
  assign misalign = 1'b0;
`endif

  fetch_wdog #(
    .TIMEOUT(TIMEOUT)
  ) u_wdog (
    .clk    (clk),
    .areset (areset),
    .clr    (wd_clr),
    .en     (wd_en),
    .expired(wd_exp)
  );

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    instr_d  = instr_q;
    ipc_d    = ipc_q;
    imem_req = 1'b0;
    wd_en    = 1'b0;
    wd_clr   = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        wd_clr  = 1'b1;
        state_d = S_REQ;
      end
      S_REQ: begin
        // Alignment fault outranks both ack and timeout
        if (misalign) begin
          err_d   = ERR_MISALIGN;
          state_d = S_ERR;
        end else begin
          imem_req = 1'b1;
          wd_en    = 1'b1;
          if (imem_ack) begin
            instr_d = imem_rdata;
            ipc_d   = pc;
            wd_clr  = 1'b1;
            state_d = S_HOLD;
          end else if (wd_exp) begin
            err_d   = ERR_TIMEOUT;
            state_d = S_ERR;
          end
        end
      end
      S_HOLD: begin
        wd_clr = 1'b1;
        if (instr_ready) begin
          state_d = S_REQ;
        end
      end
      S_ERR: begin
        wd_clr = 1'b1;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (areset) begin
      state_q <= S_IDLE;
      err_q   <= ERR_NONE;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      instr_q <= instr_d;
      ipc_q   <= ipc_d;
    end
  end

  // A reset cycle in HOLD must not advance the PC
  assign instr_valid = (state_q == S_HOLD) & ~areset;
  assign pc_load     = instr_valid & instr_ready;
  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_pc    = ipc_q;
  assign fetch_err   = (state_q == S_ERR);
  assign err_code    = err_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch.
module tb_instr_fetch;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        areset;
  logic [31:0] pc;
  logic        pc_load;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        fetch_err;
  logic [1:0]  err_code;

  int n_chk = 0;
  int n_fail = 0;

  instr_fetch #(
    .ADDR_W (32),
    .DATA_W (32),
    .TIMEOUT(TO)
  ) dut (
    .clk        (clk),
    .areset     (areset),
    .pc         (pc),
    .pc_load    (pc_load),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .instr      (instr),
    .instr_pc   (instr_pc),
    .fetch_err  (fetch_err),
    .err_code   (err_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic align_fault(input logic [31:0] a);
`ifdef FETCH_ALIGN_CHECK_EN
    return a[1:0] != 2'b00;
`else
    return 1'b0;
`endif
  endfunction

  // Leaves the bench at the negedge of the first REQ cycle
  task automatic do_reset(input logic [31:0] rpc);
    areset = 1'b1;
    imem_ack = 1'b0;
    instr_ready = 1'b0;
    imem_rdata = $urandom;
    pc = rpc;
    repeat (2) @(negedge clk);
    instr_ready = 1'b1;
    #1;
    check("rst_req", imem_req, 0);
    check("rst_valid", instr_valid, 0);
    check("rst_pcload", pc_load, 0);
    check("rst_instr", instr, 0);
    check("rst_ipc", instr_pc, 0);
    check("rst_err", fetch_err, 0);
    check("rst_code", err_code, 0);
    areset = 1'b0;
    @(negedge clk);
  endtask

  task automatic err_hold(input logic [1:0] code);
    for (int i = 0; i < 3; i++) begin
      imem_ack = 1'($urandom);
      instr_ready = 1'($urandom);
      #1;
      check("err_flag", fetch_err, 1);
      check("err_code", err_code, code);
      check("err_req", imem_req, 0);
      check("err_valid", instr_valid, 0);
      check("err_pcload", pc_load, 0);
      @(negedge clk);
    end
  endtask

  // One fetch from the current pc; enter at a REQ-cycle negedge
  task automatic fetch(input int dly, input int stall,
                       input logic [31:0] data,
                       input logic [31:0] npc, output bit err);
    logic [31:0] fpc;
    fpc = pc;
    err = 1'b0;
    if (align_fault(fpc)) begin
      imem_ack = 1'($urandom);
      #1;
      check("mis_req", imem_req, 0);
      check("mis_valid", instr_valid, 0);
      @(negedge clk);
      err = 1'b1;
      err_hold(2'b10);
      return;
    end
    for (int k = 0; ; k++) begin
      imem_ack = (k == dly);
      imem_rdata = (k == dly) ? data : $urandom;
      instr_ready = 1'($urandom);
      #1;
      check("req", imem_req, 1);
      check("req_addr", imem_addr, fpc);
      check("req_valid", instr_valid, 0);
      check("req_pcload", pc_load, 0);
      @(negedge clk);
      if (k == dly) break;
      if (k == TO - 1) begin
        err = 1'b1;
        err_hold(2'b01);
        return;
      end
    end
    for (int s = 0; s <= stall; s++) begin
      instr_ready = (s == stall);
      imem_ack = 1'($urandom);
      imem_rdata = $urandom;
      #1;
      check("hold_valid", instr_valid, 1);
      check("hold_instr", instr, data);
      check("hold_ipc", instr_pc, fpc);
      check("hold_req", imem_req, 0);
      check("hold_pcload", pc_load, 32'(s == stall));
      check("hold_err", fetch_err, 0);
      @(negedge clk);
    end
    pc = npc;
  endtask

  initial begin
    bit e;
    longint t0;
    logic [31:0] r;
    areset = 1'b1;
    pc = '0;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;

    do_reset(32'h0);
    fetch(0, 0, 32'h0000_0013, 32'h4, e);
    check("next_addr", imem_addr, 32'h4);

    // Zero-wait back-to-back: 2 cycles per instruction
    t0 = $time;
    for (int i = 0; i < 10; i++) begin
      fetch(0, 0, $urandom, pc + 32'h4, e);
    end
    check("throughput", 32'(($time - t0) / 10), 32'd20);

    fetch(3, 0, 32'hdead_beef, pc + 32'h4, e);
    fetch(0, 5, 32'h1234_5678, pc + 32'h4, e);

    fetch(TO + 1, 0, 32'h0, 32'h0, e);
    check("timeout_hit", 32'(e), 1);
    do_reset(32'h0);

    // Misaligned PC: faults only when the check is built in
    fetch(0, 0, 32'h1, 32'h6, e);
    fetch(0, 0, 32'h2, 32'h8, e);
    check("mis_result", 32'(e), 32'(align_fault(32'h6)));
    if (e) do_reset(32'h0);

    // Reset mid-REQ with a late ack landing in IDLE
    fetch(0, 0, 32'h3, 32'h40, e);
    imem_ack = 1'b0;
    #1 check("mreq_req", imem_req, 1);
    @(negedge clk);
    areset = 1'b1;
    @(negedge clk);
    areset = 1'b0;
    pc = 32'h0;
    imem_ack = 1'b1;
    imem_rdata = 32'hbad0_bad0;
    #1;
    check("mreq_idle_req", imem_req, 0);
    check("mreq_idle_valid", instr_valid, 0);
    @(negedge clk);
    fetch(1, 0, 32'h5, 32'h4, e);

    // Reset mid-HOLD: no pc_load, instruction discarded
    imem_ack = 1'b1;
    imem_rdata = 32'h7777_7777;
    @(negedge clk);
    areset = 1'b1;
    instr_ready = 1'b1;
    imem_ack = 1'b0;
    #1 check("mhold_pcload", pc_load, 0);
    @(negedge clk);
    areset = 1'b0;
    #1;
    check("mhold_valid", instr_valid, 0);
    check("mhold_instr", instr, 0);
    @(negedge clk);
    fetch(0, 0, 32'h9, 32'h8, e);

    for (int i = 0; i < 40; i++) begin
      int d;
      r = $urandom;
      if ($urandom_range(0, 7) == 0) d = TO + int'($urandom_range(0, 1));
      else d = int'($urandom_range(0, TO - 1));
      if ($urandom_range(0, 9) == 0) r[1:0] = 2'($urandom_range(1, 3));
      else r[1:0] = 2'b00;
      fetch(d, int'($urandom_range(0, 3)), $urandom, r, e);
      if (e) begin
        r = $urandom;
        r[1:0] = 2'b00;
        do_reset(r);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
# instr_fetch

Instruction fetch stage sitting directly downstream of the program counter: reads the current PC, fetches the instruction word from instruction memory over a req/ack handshake, and presents it to decode with a valid/ready handshake. When decode accepts the instruction, the block pulses `pc_load` so the program counter advances to PC+4 or the branch target. A wait-cycle watchdog and an optional alignment check drive a sticky error state.

## Interface

- `ADDR_W`, 32, width of PC and instruction memory address
- `DATA_W`, 32, instruction word width
- `TIMEOUT`, 255, maximum cycles to wait for `imem_ack` before error; range 1..255

- `clk` in 1: single clock; all logic on the rising edge
- `areset` in 1: reset, synchronous and active-high
- `pc` in ADDR_W: current PC from the program counter
- `pc_load` out 1: one-cycle pulse to the program counter's `load` input
- `imem_req` out 1: instruction memory request
- `imem_addr` out ADDR_W: fetch address; equals `pc` while `imem_req`=1
- `imem_ack` in 1: memory returns `imem_rdata` this cycle
- `imem_rdata` in DATA_W: instruction word
- `instr_valid` out 1: `instr` / `instr_pc` valid for decode
- `instr_ready` in 1: decode accepts this cycle
- `instr` out DATA_W: fetched instruction
- `instr_pc` out ADDR_W: address `instr` was fetched from
- `fetch_err` out 1: sticky error flag
- `err_code` out 2: 00 none, 01 timeout, 10 misaligned

## Operation

- States: IDLE, REQ, HOLD, ERR.
- IDLE: entered on reset; all outputs idle. Always moves to REQ on the next cycle.
- REQ:
  - `imem_req`=1 and `imem_addr`=`pc`; `wait_cnt` increments each cycle.
  - On `imem_ack`: register `instr` ← `imem_rdata` and `instr_pc` ← `pc`, clear `wait_cnt`, go to HOLD.
  - If `wait_cnt` reaches TIMEOUT with no ack: go to ERR with `err_code`=01.
- HOLD:
  - `instr_valid`=1; `instr` and `instr_pc` are held stable.
  - `pc_load` = `instr_valid & instr_ready`, combinational, in the same cycle as the handshake.
  - On handshake, go to REQ.
  - `imem_ack` is ignored in HOLD.
- ERR:
  - `fetch_err`=1; `imem_req`, `instr_valid` and `pc_load` are 0.
  - Only `areset` exits ERR.
- PC coherence: `pc_load` is asserted only in HOLD, so `pc` is stable for the whole REQ visit.
- Boundary conditions:
  - `imem_ack` in the first REQ cycle is legal (zero-wait memory).
  - `imem_ack` and timeout in the same cycle: the ack wins.
  - `imem_ack` outside REQ is ignored.
  - `instr_ready` while `instr_valid`=0 has no effect.

## Timing

- Reset values: `pc_load`=0, `imem_req`=0, `imem_addr`=`pc` (don't-care while `imem_req`=0), `instr_valid`=0, `instr`=0, `instr_pc`=0, `fetch_err`=0, `err_code`=00, state=IDLE, `wait_cnt`=0.
- Reset deasserts at edge E0; `imem_req` rises in the cycle after E0.
- Zero-wait memory: ack in REQ cycle T gives `instr_valid` in cycle T+1.
- Decode handshake in cycle H: `pc_load`=1 in H, the program counter updates at the end of H, and REQ with the new `pc` is in H+1.
- Peak throughput: one instruction per 2 cycles.
- `areset` asserted mid-REQ: `imem_req` drops after that edge; a late ack in IDLE is ignored.
- `areset` asserted mid-HOLD: the instruction is discarded and `pc_load` is not issued.

## Configuration

- Macro: `FETCH_ALIGN_CHECK_EN`.
- Defined:
  - In REQ, if `pc[1:0]` ≠ 00, no request is issued (`imem_req`=0 that cycle).
  - Next state is ERR with `err_code`=10.
  - The check is evaluated before the ack and timeout checks.
- Undefined:
  - No check; `imem_addr`=`pc` unmodified.
  - `err_code` 10 is never produced.

## Structure

- Package `fetch_pkg`:
  - State enum (IDLE/REQ/HOLD/ERR).
  - Error code constants ERR_NONE/ERR_TIMEOUT/ERR_MISALIGN.
  - Default TIMEOUT.
- One sub-module, `fetch_wdog`:
  - 8-bit wait counter with `clr`, `en` and an `expired` output at TIMEOUT.
  - Same clock and reset as the parent.

## Test plan

- Reset then zero-wait memory returning 0x00000013 at PC 0x0, `instr_ready`=1 → `instr_valid` 2 cycles after reset release, `instr_pc`=0x0, `pc_load` pulse in the same cycle, next `imem_addr`=0x4.
- `imem_ack` delayed 3 cycles → `imem_req` held 4 cycles, `imem_addr` stable, `instr`=`imem_rdata` from the ack cycle.
- `instr_ready`=0 for 5 cycles in HOLD → `instr` and `instr_pc` stable, `pc_load`=0, no new `imem_req`; a single `pc_load` when ready rises.
- TIMEOUT=4, `imem_ack` never asserted → ERR after 4 REQ cycles, `fetch_err`=1, `err_code`=01, held until `areset`.
- With `FETCH_ALIGN_CHECK_EN` and `pc`=0x6 → no `imem_req`, `err_code`=10; without the macro → normal fetch at 0x6.
- `areset` during REQ with ack arriving one cycle later → ack ignored, `instr_valid` stays 0, refetch from the reset PC 0x0.
